// File: rtl/sfifo_ctl.sv
// Single-clock FIFO controller with standard or first-word-fall-through read,
// programmable thresholds, occupancy/peak tracking and sticky error flags.
module sfifo_ctl #(
    parameter int DEEPWID = 3,
    parameter int DEEP    = 8,
    parameter int BITWID  = 8,
    parameter int FWFT    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr,
    input  logic [BITWID-1:0]  wr_dat,
    input  logic               rd,
    output logic [BITWID-1:0]  rd_dat,
    output logic               rd_dat_vld,
    input  logic [DEEPWID:0]   cfg_almost_full,
    input  logic [DEEPWID:0]   cfg_almost_empty,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [DEEPWID:0]   data_num,
    output logic [DEEPWID:0]   peak_num,
    output logic               ovf,
    output logic               udf,
    input  logic               err_clr
);

    logic [BITWID-1:0] mem [DEEP];
    logic [DEEPWID:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              wr_acc, rd_acc, vld_nxt;
    logic [BITWID-1:0] rd_dat_nxt;

    assign data_num     = wr_ptr - rd_ptr;
    assign full         = (data_num == (DEEPWID+1)'(DEEP));
    assign empty        = (data_num == '0);
    assign almost_full  = (data_num >= cfg_almost_full);
    assign almost_empty = (data_num <= cfg_almost_empty);

    // In FWFT mode rd_dat_vld mirrors !empty, so both forms gate on a present head.
    assign rd_acc     = (FWFT != 0) ? (rd & rd_dat_vld) : (rd & ~empty);
    assign wr_acc     = wr & (~full | rd_acc);
    assign wr_ptr_nxt = wr_ptr + {{DEEPWID{1'b0}}, wr_acc};
    assign rd_ptr_nxt = rd_ptr + {{DEEPWID{1'b0}}, rd_acc};

    always_comb begin
        rd_dat_nxt = rd_dat;
        vld_nxt    = 1'b0;
        if (FWFT != 0) begin
            vld_nxt = (wr_ptr_nxt != rd_ptr_nxt);
            // The next head may be the slot being written this very cycle.
            if (vld_nxt)
                rd_dat_nxt = (wr_acc && (rd_ptr_nxt == wr_ptr)) ? wr_dat
                                                                 : mem[rd_ptr_nxt[DEEPWID-1:0]];
        end else begin
            vld_nxt = rd_acc;
            if (rd_acc)
                rd_dat_nxt = mem[rd_ptr[DEEPWID-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[DEEPWID-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_dat     <= '0;
            rd_dat_vld <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_dat     <= rd_dat_nxt;
            rd_dat_vld <= vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            udf      <= 1'b0;
            peak_num <= '0;
        end else if (err_clr) begin
            ovf      <= 1'b0;
            udf      <= 1'b0;
            peak_num <= '0;
        end else begin
            if (wr & ~wr_acc)
                ovf <= 1'b1;
            if (rd & ~rd_acc)
                udf <= 1'b1;
            if (data_num > peak_num)
                peak_num <= data_num;
        end
    end

endmodule

// File: tb/tb_sfifo_ctl.sv
// Drives a standard-mode and an FWFT-mode sfifo_ctl with shared stimulus and
// checks both against queue-based reference models every cycle.
module tb_sfifo_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_dat = '0;
    logic [3:0] cfg_af = 4'd6, cfg_ae = 4'd2;

    logic [7:0] d0_dat, d1_dat;
    logic       d0_vld, d1_vld, d0_full, d1_full, d0_empty, d1_empty;
    logic       d0_af, d1_af, d0_ae, d1_ae, d0_ovf, d1_ovf, d0_udf, d1_udf;
    logic [3:0] d0_num, d1_num, d0_peak, d1_peak;

    int checks = 0;
    int fails  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_peak[2];
    bit         m_ovf[2], m_udf[2], m_vld[2];
    logic [7:0] m_dat[2];

    always #5 clk = ~clk;

    sfifo_ctl #(.DEEPWID(3), .DEEP(8), .BITWID(8), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_dat(wr_dat), .rd(rd),
        .rd_dat(d0_dat), .rd_dat_vld(d0_vld),
        .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
        .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
        .data_num(d0_num), .peak_num(d0_peak), .ovf(d0_ovf), .udf(d0_udf),
        .err_clr(err_clr));

    sfifo_ctl #(.DEEPWID(3), .DEEP(8), .BITWID(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_dat(wr_dat), .rd(rd),
        .rd_dat(d1_dat), .rd_dat_vld(d1_vld),
        .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
        .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
        .data_num(d1_num), .peak_num(d1_peak), .ovf(d1_ovf), .udf(d1_udf),
        .err_clr(err_clr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qhead(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic mdl_reset();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            m_peak[m] = 0; m_ovf[m] = 0; m_udf[m] = 0; m_vld[m] = 0; m_dat[m] = '0;
        end
    endtask

    // One clock of the reference: what the FIFO rules say happens at this edge.
    task automatic mdl_step(input int m);
        int n;
        bit racc, wacc;
        logic [7:0] popped;
        n      = qsize(m);
        popped = '0;
        racc   = rd && (n > 0);
        wacc   = wr && ((n < 8) || racc);
        if (racc) begin
            if (m == 0) popped = q0.pop_front(); else popped = q1.pop_front();
        end
        if (wacc) begin
            if (m == 0) q0.push_back(wr_dat); else q1.push_back(wr_dat);
        end
        if (m == 0) begin
            m_vld[0] = racc;
            if (racc) m_dat[0] = popped;
        end else begin
            m_vld[1] = (q1.size() > 0);
            if (m_vld[1]) m_dat[1] = q1[0];
        end
        if (err_clr) begin
            m_ovf[m] = 0; m_udf[m] = 0; m_peak[m] = 0;
        end else begin
            if (wr && !wacc) m_ovf[m] = 1;
            if (rd && !racc) m_udf[m] = 1;
            if (n > m_peak[m]) m_peak[m] = n;
        end
    endtask

    task automatic chk_dut(input int m, input logic [3:0] num, input logic [3:0] peak,
                           input logic fu, input logic em, input logic af, input logic ae,
                           input logic ov, input logic ud, input logic vl, input logic [7:0] dat);
        int n;
        n = qsize(m);
        chk($sformatf("m%0d data_num", m), 32'(num), 32'(n));
        chk($sformatf("m%0d full", m), 32'(fu), 32'(n == 8));
        chk($sformatf("m%0d empty", m), 32'(em), 32'(n == 0));
        chk($sformatf("m%0d almost_full", m), 32'(af), 32'(n >= int'(cfg_af)));
        chk($sformatf("m%0d almost_empty", m), 32'(ae), 32'(n <= int'(cfg_ae)));
        chk($sformatf("m%0d peak_num", m), 32'(peak), 32'(m_peak[m]));
        chk($sformatf("m%0d ovf", m), 32'(ov), 32'(m_ovf[m]));
        chk($sformatf("m%0d udf", m), 32'(ud), 32'(m_udf[m]));
        chk($sformatf("m%0d rd_dat_vld", m), 32'(vl), 32'(m_vld[m]));
        if (m == 0)
            chk("m0 rd_dat", 32'(dat), 32'(m_dat[0]));
        else if (m_vld[1])
            chk("m1 rd_dat head", 32'(dat), 32'(qhead(1)));
    endtask

    task automatic check_all();
        chk_dut(0, d0_num, d0_peak, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_vld, d0_dat);
        chk_dut(1, d1_num, d1_peak, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf, d1_vld, d1_dat);
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        wr = w; wr_dat = d; rd = r; err_clr = c;
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset();
        wr = 0; rd = 0; err_clr = 0;
        #2 rst_n = 1'b0;
        #1;
        mdl_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        int wp, rp;
        mdl_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Fill past full, then drain: 0x09 must be rejected and never read back.
        for (int i = 1; i <= 9; i++) step(1, 8'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Read on empty together with a write, then a real read.
        step(1, 8'hAA, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Single write then a pop.
        step(1, 8'h5C, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Full-rate streaming at full occupancy, then drain through thresholds.
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 1, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Threshold edge values.
        cfg_af = 4'd0; cfg_ae = 4'd8;
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        cfg_af = 4'd6; cfg_ae = 4'd2;

        // Reset mid-burst at occupancy 5, then behave as empty.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
        async_reset();
        step(0, 8'h00, 1, 0);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Randomized traffic with shifting write/read bias and thresholds.
        for (int blk = 0; blk < 40; blk++) begin
            cfg_af = 4'($urandom_range(0, 8));
            cfg_ae = 4'($urandom_range(0, 8));
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 60; i++)
                step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
                     ($urandom_range(0, 49) == 0));
            if ((blk % 13) == 12) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
